// File: rtl/serial_alu_pkg.sv
// serial_alu_pkg: op codes, FSM states and op-class helpers for the bit-serial ALU
package serial_alu_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_SHIFT} state_t;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  function automatic logic is_shift(input logic [3:0] ctl);
    return ctl[2:0] == F3_SLL || ctl[2:0] == F3_SR;
  endfunction
  function automatic logic is_inv(input logic [3:0] ctl);
    return ctl == 4'b1000 || ctl[2:0] == F3_SLT || ctl[2:0] == F3_SLTU;
  endfunction
endpackage

// File: rtl/serial_alu_bitslice_adder.sv
// bitslice_adder: one full-adder slice with its carry flop
module bitslice_adder (
  input  logic clk,
  input  logic rst,
  input  logic init_en,
  input  logic init_val,
  input  logic en,
  input  logic a,
  input  logic b,
  input  logic inv_b,
  output logic sum,
  output logic carry
);
  logic w_b;
  assign w_b = b ^ inv_b;
  assign sum = a ^ w_b ^ carry;
  always_ff @(posedge clk)
    carry <= rst ? 1'b0 : init_en ? init_val : en ? (a & w_b) | (a & carry) | (w_b & carry) : carry;
endmodule

// File: rtl/serial_alu.sv
// serial_alu: LSB-first bit-serial RV32I ALU with parallel operands and result
module serial_alu
  import serial_alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int CNTW = 5
) (
  input  logic            w_clk,
  input  logic            w_rst,
  input  logic            w_start,
  input  logic [3:0]      w_ctl,
  input  logic [XLEN-1:0] w_a,
  input  logic [XLEN-1:0] w_b,
  output logic            r_busy,
  output logic            r_done,
  output logic [XLEN-1:0] r_rslt
);
  state_t            r_state;
  logic [XLEN-1:0]   r_a, r_b, r_res;
  logic [3:0]        r_ctl;
  logic [CNTW-1:0]   r_cnt;
  logic              w_sum, w_carry, w_inv, w_bi, w_cout, w_bit, w_last;
  logic [XLEN-1:0]   w_word, w_sh;
  logic [CNTW-1:0]   w_n;
  logic [2:0]        w_f3;
  assign w_f3   = r_ctl[2:0];
  assign w_inv  = is_inv(r_ctl);
  assign w_bi   = r_b[0] ^ w_inv;
  assign w_cout = (r_a[0] & w_bi) | (r_a[0] & w_carry) | (w_bi & w_carry);
  assign w_n    = r_b[CNTW-1:0];
  assign w_last = r_cnt == CNTW'(XLEN - 1);
  bitslice_adder u_add (
    .clk      (w_clk),
    .rst      (w_rst),
    .init_en  (r_state == ST_IDLE && w_start),
    .init_val (is_inv(w_ctl)),
    .en       (r_state == ST_RUN),
    .a        (r_a[0]),
    .b        (r_b[0]),
    .inv_b    (w_inv),
    .sum      (w_sum),
    .carry    (w_carry)
  );
  always_comb begin
    w_bit  = w_f3 == F3_XOR ? r_a[0] ^ r_b[0] :
             w_f3 == F3_OR  ? r_a[0] | r_b[0] :
             w_f3 == F3_AND ? r_a[0] & r_b[0] : w_sum;
    // at the last bit r_a[0]/r_b[0] hold the operand sign bits
    w_word = w_f3 == F3_SLT  ? {{(XLEN-1){1'b0}}, (r_a[0] != r_b[0]) ? r_a[0] : w_sum} :
             w_f3 == F3_SLTU ? {{(XLEN-1){1'b0}}, ~w_cout} : {w_bit, r_res[XLEN-1:1]};
    w_sh   = w_f3 == F3_SLL ? {r_a[XLEN-2:0], 1'b0} : {r_ctl[3] & r_a[XLEN-1], r_a[XLEN-1:1]};
  end
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rslt  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_ctl   <= '0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_start) begin
          r_a     <= w_a;
          r_b     <= w_b;
          r_ctl   <= w_ctl;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
          r_state <= is_shift(w_ctl) ? ST_SHIFT : ST_RUN;
        end
        ST_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_res <= {w_bit, r_res[XLEN-1:1]};
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_rslt  <= w_word;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_SHIFT: if (w_n == '0) begin
          r_rslt  <= r_a;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end else begin
          r_a   <= w_sh;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == w_n - 1'b1) begin
            r_rslt  <= w_sh;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_alu.sv
// tb_serial_alu: directed and random checks of serial_alu against an arithmetic reference model
module tb_serial_alu;
  logic        clk = 0, rst = 1, start = 0;
  logic [3:0]  ctl = 0;
  logic [31:0] a = 0, b = 0;
  logic        busy, done;
  logic [31:0] rslt;
  int          n_tests = 0, n_fail = 0;

  serial_alu dut (
    .w_clk(clk), .w_rst(rst), .w_start(start), .w_ctl(ctl), .w_a(a), .w_b(b),
    .r_busy(busy), .r_done(done), .r_rslt(rslt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    case (c[2:0])
      3'b000: return c[3] ? x - y : x + y;
      3'b001: return x << y[4:0];
      3'b010: return {31'b0, $signed(x) < $signed(y)};
      3'b011: return {31'b0, x < y};
      3'b100: return x ^ y;
      3'b101: return c[3] ? 32'($signed(x) >>> y[4:0]) : x >> y[4:0];
      3'b110: return x | y;
      default: return x & y;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] c, input logic [31:0] y);
    if (c[2:0] == 3'b001 || c[2:0] == 3'b101) return (y[4:0] == 0) ? 1 : int'(y[4:0]);
    return 32;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1; ctl = c; a = x; b = y;
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic do_op(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp, input int exp_lat, input string tag);
    int lat;
    launch(c, x, y);
    chk({tag, " busy"}, 32'(busy), 32'd1);
    wait_done(lat);
    chk({tag, " lat"}, lat, exp_lat);
    chk({tag, " rslt"}, rslt, exp);
    @(posedge clk);
    #1 chk({tag, " pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    logic [3:0]  rc;
    logic [31:0] ra, rb;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst rslt", rslt, 0);
    @(negedge clk) rst = 0;

    do_op(4'b0000, 32'h7FFFFFFF, 32'h1, 32'h80000000, 32, "add_ovf");
    do_op(4'b1000, 32'd5, 32'd7, 32'hFFFFFFFE, 32, "sub");
    do_op(4'b0010, 32'hFFFFFFFF, 32'h1, 32'h1, 32, "slt");
    do_op(4'b0011, 32'hFFFFFFFF, 32'h1, 32'h0, 32, "sltu");
    do_op(4'b0010, 32'h80000000, 32'h80000000, 32'h0, 32, "slt_eq");
    do_op(4'b1101, 32'h80000000, 32'd4, 32'hF8000000, 4, "sra");
    do_op(4'b0101, 32'h80000000, 32'd4, 32'h08000000, 4, "srl");
    do_op(4'b0001, 32'h12345678, 32'd0, 32'h12345678, 1, "sll0");
    do_op(4'b0001, 32'h12345678, 32'hFFFFFFE1, 32'h2468ACF0, 1, "sll1");
    do_op(4'b0111, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32, "and");
    do_op(4'b0110, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 32, "or");
    do_op(4'b0100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 32, "xor");
    do_op(4'b1111, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32, "and_f7");

    launch(4'b0000, 32'd1, 32'd2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1; ctl = 4'b0000; a = 32'd9; b = 32'd9;
    @(posedge clk);
    #1 start = 0;
    wait_done(lat);
    chk("ignore lat", lat, 28);
    chk("ignore rslt", rslt, 32'd3);

    launch(4'b0000, 32'd5, 32'd5);
    repeat (9) @(posedge clk);
    @(negedge clk) rst = 1;
    @(posedge clk);
    #1;
    chk("mid_rst busy", 32'(busy), 0);
    chk("mid_rst done", 32'(done), 0);
    chk("mid_rst rslt", rslt, 0);
    @(negedge clk) rst = 0;
    do_op(4'b0000, 32'd2, 32'd2, 32'd4, 32, "post_rst");

    launch(4'b1000, 32'd5, 32'd7);
    wait_done(lat);
    chk("b2b sub lat", lat, 32);
    chk("b2b sub rslt", rslt, 32'hFFFFFFFE);
    chk("b2b sub done", 32'(done), 1);
    start = 1; ctl = 4'b0100; a = 32'hFFFFFFFF; b = 32'h1;
    @(posedge clk);
    #1 start = 0;
    chk("b2b pulse", 32'(done), 0);
    chk("b2b busy", 32'(busy), 1);
    wait_done(lat);
    chk("b2b xor lat", lat, 32);
    chk("b2b xor rslt", rslt, 32'hFFFFFFFE);

    for (int i = 0; i < 60; i++) begin
      rc = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = (i % 4 == 0) ? ra : $urandom;
      if (i % 7 == 0) ra = 32'h80000000;
      do_op(rc, ra, rb, ref_alu(rc, ra, rb), ref_lat(rc, rb), $sformatf("rnd%0d c=%h", i, rc));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
